// File: rtl/bcd_updown_counter_7seg.sv
// NUM_DIGITS-wide BCD up/down counter with prescaler, parallel load, wrap pulse and 7-segment decode.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading-zero digits on the displays.
module bcd_updown_counter_7seg #(
  parameter int NUM_DIGITS     = 2,
  parameter int CLK_DIV        = 50000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic                    wrap
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [PW-1:0]           presc_q, presc_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic                    wrap_q, wrap_d;
  logic                    tick;
  logic                    carry;
  logic [NUM_DIGITS-1:0]   blank;

  // Active-high pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0111111;
      4'd1:    seg_decode = 7'b0000110;
      4'd2:    seg_decode = 7'b1011011;
      4'd3:    seg_decode = 7'b1001111;
      4'd4:    seg_decode = 7'b1100110;
      4'd5:    seg_decode = 7'b1101101;
      4'd6:    seg_decode = 7'b1111101;
      4'd7:    seg_decode = 7'b0000111;
      4'd8:    seg_decode = 7'b1111111;
      4'd9:    seg_decode = 7'b1101111;
      default: seg_decode = 7'b0000000;
    endcase
  endfunction

  always_comb begin
    presc_d  = presc_q;
    digits_d = digits_q;
    wrap_d   = 1'b0;
    carry    = 1'b1;
    tick     = enable && (presc_q == PRESC_MAX);
    if (load) begin
      presc_d = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
        digits_d[i*4 +: 4] = (load_value[i*4 +: 4] > 4'd9) ? 4'd0 : load_value[i*4 +: 4];
    end else if (tick) begin
      presc_d = '0;
      // carry doubles as the borrow when counting down; it survives the top digit only on wrap
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (carry) begin
          if (up_down) begin
            if (digits_q[i*4 +: 4] == 4'd9) digits_d[i*4 +: 4] = 4'd0;
            else begin
              digits_d[i*4 +: 4] = digits_q[i*4 +: 4] + 4'd1;
              carry = 1'b0;
            end
          end else begin
            if (digits_q[i*4 +: 4] == 4'd0) digits_d[i*4 +: 4] = 4'd9;
            else begin
              digits_d[i*4 +: 4] = digits_q[i*4 +: 4] - 4'd1;
              carry = 1'b0;
            end
          end
        end
      end
      wrap_d = carry;
    end else if (enable) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q  <= '0;
      digits_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      digits_q <= digits_d;
      wrap_q   <= wrap_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic run;
    run   = 1'b1;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run      = run && (digits_q[i*4 +: 4] == 4'd0);
      blank[i] = run;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    seg = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (blank[i])            seg[i*7 +: 7] = SEG_OFF;
      else if (SEG_ACTIVE_LOW) seg[i*7 +: 7] = ~seg_decode(digits_q[i*4 +: 4]);
      else                     seg[i*7 +: 7] = seg_decode(digits_q[i*4 +: 4]);
    end
  end

  assign bcd  = digits_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_updown_counter_7seg.sv
// Directed self-checking bench for bcd_updown_counter_7seg (2 digits, CLK_DIV=4, active-low segments).
module tb_bcd_updown_counter_7seg;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        up_down;
  logic        load;
  logic [7:0]  load_value;
  logic [7:0]  bcd;
  logic [13:0] seg;
  logic        wrap;

  int compared = 0;
  int mismatched = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S9 = 7'b0010000;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] HI_ZERO = 7'h7F;
`else
  localparam logic [6:0] HI_ZERO = S0;
`endif

  bcd_updown_counter_7seg #(.NUM_DIGITS(2), .CLK_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .bcd(bcd), .seg(seg), .wrap(wrap)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0; load_value = 8'h00;
    step(3);
    check("rst_bcd", 32'(bcd), 32'h00);
    check("rst_seg", 32'(seg), 32'({HI_ZERO, S0}));
    check("rst_wrap", 32'(wrap), 32'h0);

    // count to 07, then reset asynchronously mid-period
    reset = 1'b0; enable = 1'b1;
    step(28);
    check("cnt_07", 32'(bcd), 32'h07);
    step(2);
    #4 reset = 1'b1;
    #1;
    check("async_rst_bcd", 32'(bcd), 32'h00);
    check("async_rst_seg", 32'(seg), 32'({HI_ZERO, S0}));
    check("async_rst_wrap", 32'(wrap), 32'h0);
    step(5);
    check("rst_hold_bcd", 32'(bcd), 32'h00);
    @(posedge clk); #1 reset = 1'b0;

    // up count with carry
    step(3);
    check("up_pre_tick", 32'(bcd), 32'h00);
    step(1);
    check("up_first", 32'(bcd), 32'h01);
    step(36);
    check("up_carry_bcd", 32'(bcd), 32'h10);
    check("up_carry_seg", 32'(seg), 32'({S1, S0}));
    check("up_carry_wrap", 32'(wrap), 32'h0);

    // up wrap
    load = 1'b1; load_value = 8'h99;
    step(1);
    load = 1'b0;
    check("load99_bcd", 32'(bcd), 32'h99);
    check("load99_seg", 32'(seg), 32'({S9, S9}));
    check("load99_wrap", 32'(wrap), 32'h0);
    step(3);
    check("pre_wrap_bcd", 32'(bcd), 32'h99);
    step(1);
    check("upwrap_bcd", 32'(bcd), 32'h00);
    check("upwrap_pulse", 32'(wrap), 32'h1);
    step(1);
    check("upwrap_pulse_end", 32'(wrap), 32'h0);

    // down wrap
    up_down = 1'b0;
    step(2);
    check("dn_pre_tick", 32'(bcd), 32'h00);
    step(1);
    check("dnwrap_bcd", 32'(bcd), 32'h99);
    check("dnwrap_pulse", 32'(wrap), 32'h1);
    step(1);
    check("dnwrap_pulse_end", 32'(wrap), 32'h0);
    step(3);
    check("down_98", 32'(bcd), 32'h98);

    // borrow across digits
    load = 1'b1; load_value = 8'h10;
    step(1);
    load = 1'b0;
    step(4);
    check("borrow_09", 32'(bcd), 32'h09);
    check("borrow_wrap", 32'(wrap), 32'h0);

    // enable gating resumes partial period
    up_down = 1'b1;
    step(2);
    enable = 1'b0;
    step(10);
    check("gated_bcd", 32'(bcd), 32'h09);
    enable = 1'b1;
    step(1);
    check("resume_1", 32'(bcd), 32'h09);
    step(1);
    check("resume_2", 32'(bcd), 32'h10);

    // load in the tick cycle wins, invalid digit becomes 0
    step(3);
    load = 1'b1; load_value = 8'h3C;
    step(1);
    load = 1'b0;
    check("ldprio_bcd", 32'(bcd), 32'h30);
    check("ldprio_wrap", 32'(wrap), 32'h0);
    step(3);
    check("ldprio_hold", 32'(bcd), 32'h30);
    step(1);
    check("ldprio_next", 32'(bcd), 32'h31);

    // load while disabled, invalid upper digit
    enable = 1'b0;
    load = 1'b1; load_value = 8'hA5;
    step(1);
    load = 1'b0;
    check("ld_dis_bcd", 32'(bcd), 32'h05);
    check("ld_dis_seg", 32'(seg), 32'({HI_ZERO, 7'b0010010}));
    step(6);
    check("ld_dis_hold", 32'(bcd), 32'h05);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
